// File: rtl/resp_router.sv
// resp_router: tracks outstanding bus reads and which cache issued each one,
// then steers every response beat back to that cache and returns the cache's
// per-beat acknowledge to the bus. Unmatched beats are acked and dropped.
module resp_router #(
  parameter int BUS_DATA_WIDTH = 64,
  parameter int BUS_TAG_WIDTH  = 13,
  parameter int DEPTH          = 4,
  parameter int BEATS          = 8
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      bus_reqcyc,
  input  logic [BUS_TAG_WIDTH-1:0]  bus_reqtag,
  input  logic                      bus_reqack,
  input  logic                      req_owner,
  input  logic                      bus_respcyc,
  input  logic [BUS_DATA_WIDTH-1:0] bus_resp,
  input  logic [BUS_TAG_WIDTH-1:0]  bus_resptag,
  output logic                      bus_respack,
  output logic                      ic_respcyc,
  output logic                      dc_respcyc,
  output logic [BUS_DATA_WIDTH-1:0] ic_resp,
  output logic [BUS_DATA_WIDTH-1:0] dc_resp,
  output logic [BUS_TAG_WIDTH-1:0]  ic_resptag,
  output logic [BUS_TAG_WIDTH-1:0]  dc_resptag,
  input  logic                      ic_respack,
  input  logic                      dc_respack,
  output logic                      table_full,
  output logic                      err_unmatched,
  output logic                      err_overflow
);

  localparam int CNT_W = $clog2(BEATS + 1);
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

  // Transaction table: owner 0 = I-cache, 1 = D-cache.
  logic [DEPTH-1:0]         valid_q, valid_d;
  logic [DEPTH-1:0]         owner_q, owner_d;
  logic [BUS_TAG_WIDTH-1:0] tag_q [DEPTH];
  logic [BUS_TAG_WIDTH-1:0] tag_d [DEPTH];
  logic [CNT_W-1:0]         cnt_q [DEPTH];
  logic [CNT_W-1:0]         cnt_d [DEPTH];
  logic                     err_unmatched_q, err_unmatched_d;
  logic                     err_overflow_q, err_overflow_d;

  logic [DEPTH-1:0] alloc_oh;
  logic [DEPTH-1:0] hit_oh;
  logic             hit;
  logic             hit_owner;
  logic             rd_accept;
  logic             beat_xfer;

  assign table_full    = &valid_q;
  assign err_unmatched = err_unmatched_q;
  assign err_overflow  = err_overflow_q;

  // Writes carry the tag MSB and never produce a response, so they are ignored.
  assign rd_accept = bus_reqcyc && bus_reqack && !bus_reqtag[BUS_TAG_WIDTH-1];
  assign hit       = |hit_oh;
  assign hit_owner = |(hit_oh & owner_q);
  assign beat_xfer = bus_respcyc && bus_respack && hit;

  // Priority pick: lowest free slot for allocation, lowest matching slot for lookup.
  always_comb begin
    alloc_oh = '0;
    hit_oh   = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (!valid_q[i] && (alloc_oh == '0)) alloc_oh[i] = 1'b1;
      if (valid_q[i] && (tag_q[i] == bus_resptag) && (hit_oh == '0)) hit_oh[i] = 1'b1;
    end
  end

  // Zero-latency steering; a miss is acked so the bus can drop the beat.
  always_comb begin
    bus_respack = 1'b0;
    ic_respcyc  = 1'b0;
    dc_respcyc  = 1'b0;
    ic_resp     = '0;
    dc_resp     = '0;
    ic_resptag  = '0;
    dc_resptag  = '0;
    if (hit) begin
      if (!hit_owner) begin
        ic_respcyc  = bus_respcyc;
        ic_resp     = bus_resp;
        ic_resptag  = bus_resptag;
        bus_respack = ic_respack;
      end else begin
        dc_respcyc  = bus_respcyc;
        dc_resp     = bus_resp;
        dc_resptag  = bus_resptag;
        bus_respack = dc_respack;
      end
    end else begin
      bus_respack = bus_respcyc;
    end
  end

  // Table next state: count/free on acked hits, allocate new reads into a free slot.
  // Free and allocate may coincide; they always target different entries.
  always_comb begin
    valid_d = valid_q;
    owner_d = owner_q;
    tag_d   = tag_q;
    cnt_d   = cnt_q;
    for (int i = 0; i < DEPTH; i++) begin
      if (beat_xfer && hit_oh[i]) begin
        if (cnt_q[i] == LAST_BEAT) begin
          valid_d[i] = 1'b0;
          cnt_d[i]   = '0;
        end else begin
          cnt_d[i] = cnt_q[i] + CNT_W'(1);
        end
      end
      if (rd_accept && !table_full && alloc_oh[i]) begin
        valid_d[i] = 1'b1;
        owner_d[i] = req_owner;
        tag_d[i]   = bus_reqtag;
        cnt_d[i]   = '0;
      end
    end
    err_unmatched_d = err_unmatched_q | (bus_respcyc && !hit);
    err_overflow_d  = err_overflow_q  | (rd_accept && table_full);
  end

  // State registers; reset discards every outstanding transaction.
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q         <= '0;
      owner_q         <= '0;
      err_unmatched_q <= 1'b0;
      err_overflow_q  <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        tag_q[i] <= '0;
        cnt_q[i] <= '0;
      end
    end else begin
      valid_q         <= valid_d;
      owner_q         <= owner_d;
      err_unmatched_q <= err_unmatched_d;
      err_overflow_q  <= err_overflow_d;
      for (int i = 0; i < DEPTH; i++) begin
        tag_q[i] <= tag_d[i];
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

endmodule

// File: doc/resp_router.md
# resp_router

Response-side companion to the cache/bus request arbiter. It tracks every read request the arbiter hands to the memory bus and records which cache (I-cache or D-cache) issued it. It then steers each multi-beat bus response back to that cache and returns that cache's per-beat acknowledge to the bus. It sits between the memory bus response channel and the two cache response ports.

## Interface
Parameters:
- BUS_DATA_WIDTH, 64, width of request and response data
- BUS_TAG_WIDTH, 13, tag width; bit BUS_TAG_WIDTH-1 set means write
- DEPTH, 4, number of outstanding read transactions tracked
- BEATS, 8, response beats per read transaction

Ports (clock is clk; reset is reset, synchronous, active-high):
- clk  input  1  clock
- reset  input  1  synchronous active-high reset
- bus_reqcyc  input  1  request valid as driven onto the bus by the arbiter
- bus_reqtag  input  BUS_TAG_WIDTH  request tag on the bus
- bus_reqack  input  1  bus accepts the current request
- req_owner  input  1  source of the current bus request: 0 = I-cache, 1 = D-cache
- bus_respcyc  input  1  response beat valid
- bus_resp  input  BUS_DATA_WIDTH  response beat data
- bus_resptag  input  BUS_TAG_WIDTH  response tag
- bus_respack  output  1  beat consumed
- ic_respcyc, dc_respcyc  output  1  beat valid toward each cache
- ic_resp, dc_resp  output  BUS_DATA_WIDTH  beat data toward each cache
- ic_resptag, dc_resptag  output  BUS_TAG_WIDTH  beat tag toward each cache
- ic_respack, dc_respack  input  1  cache consumed beat
- table_full  output  1  all DEPTH entries valid; the arbiter must not present a new read
- err_unmatched  output  1  sticky: beat arrived with no matching entry
- err_overflow  output  1  sticky: read accepted while table_full

## Operation
- Table: DEPTH entries, each holding valid, tag, owner and a beat count of clog2(BEATS+1) bits.
- Allocate: on a cycle with bus_reqcyc && bus_reqack && !bus_reqtag[MSB] && !table_full:
  - write the lowest-index invalid entry with {valid=1, tag=bus_reqtag, owner=req_owner, count=0}.
- Writes (tag MSB = 1) get no response and are never recorded.
- Accept while table_full: no entry is written and err_overflow sets.
- Lookup: a hit is the lowest-index valid entry whose tag equals bus_resptag.
- Route, combinational from inputs and table state:
  - Hit, owner 0: ic_respcyc=bus_respcyc; ic_resp=bus_resp; ic_resptag=bus_resptag; bus_respack=ic_respack; dc_respcyc=0.
  - Hit, owner 1: the mirror image through the dc_* ports.
- Data/tag outputs of the non-selected cache are 0.
- Miss with bus_respcyc=1: both cache respcyc outputs are 0, bus_respack=1 (the beat is dropped), and err_unmatched sets.
- Beat counting: on bus_respcyc && bus_respack && hit, the entry's count increments. When the count reaches BEATS-1 and the beat is acked, the entry is cleared (valid=0).
- Error flags clear only on reset.

## Timing
- Reset: table cleared, err_* = 0, table_full = 0.
  - With bus_respcyc = 0, every output is 0.
  - Reset in the middle of a transaction discards all outstanding entries; later beats of those transactions are misses.
- Routing latency is 0 cycles: a beat is visible to the cache in the same cycle it appears on the bus.
- Table updates take effect at the next posedge.
- A beat is transferred only in a cycle where respcyc and the corresponding respack are both 1. A beat without an ack is held by the bus and must be routed identically in the next cycle.
- Allocation and final-beat free in the same cycle both occur.
  - The freed slot is usable from the next cycle.
  - table_full reflects registered state, so it does not drop in the same cycle as the free.
- A response may arrive in the cycle after allocation; it must not arrive in the allocation cycle itself.
- Two in-flight reads with the same tag are served in allocation order when they occupy ascending indices. Otherwise the lowest-index entry wins.

## Test plan
- I-cache read, tag 0x010 accepted, 8 beats with ic_respack=1 each cycle → ic_respcyc high for 8 cycles; dc_respcyc=0 throughout; entry freed; table_full=0.
- D-cache read, tag 0x020; dc_respack held low on beat 3 for 2 cycles → bus_respack=0 during the stall; beat data stable; total 8 acked beats, then entry freed.
- Interleaved: I-cache read 0x011 and D-cache read 0x022 outstanding; beats for 0x022 arrive first → all go to dc; the following 0x011 beats go to ic.
- Write accept, tag 0x1005 → no entry allocated. A beat with tag 0x1234 (no matching read) → bus_respack=1, err_unmatched=1, neither cache sees respcyc.
- Fill all 4 entries → table_full=1. A fifth read accepted → err_overflow=1, nothing recorded. Final beat of entry 0 → table_full=0 the next cycle.
- Reset asserted after beat 4 of a live read → all outputs 0. Remaining beats are treated as unmatched, and err_unmatched sets after reset deasserts.
